// File: rtl/jt08_adpcmb_pkg.sv
// Shared constants for the ADPCM-B register front-end: register offsets,
// ctrl1 bit positions, memory FSM state encoding and the address shift.
package jt08_adpcmb_pkg;

    localparam logic [3:0] REG_CTRL1   = 4'h0;
    localparam logic [3:0] REG_CTRL2   = 4'h1;
    localparam logic [3:0] REG_START_L = 4'h2;
    localparam logic [3:0] REG_START_H = 4'h3;
    localparam logic [3:0] REG_STOP_L  = 4'h4;
    localparam logic [3:0] REG_STOP_H  = 4'h5;
    localparam logic [3:0] REG_DATA    = 4'h8;
    localparam logic [3:0] REG_DELTA_L = 4'h9;
    localparam logic [3:0] REG_DELTA_H = 4'hA;
    localparam logic [3:0] REG_LEVEL   = 4'hB;
    localparam logic [3:0] REG_LIMIT_L = 4'hC;
    localparam logic [3:0] REG_LIMIT_H = 4'hD;

    localparam int unsigned CTRL1_START   = 7;
    localparam int unsigned CTRL1_REC     = 6;
    localparam int unsigned CTRL1_MEMDATA = 5;
    localparam int unsigned CTRL1_REPEAT  = 4;
    localparam int unsigned CTRL1_RESET   = 0;

    // Register addresses are in 32-byte units
    localparam int unsigned ADDR_SHIFT = 5;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_REQ  = 2'd1;
    localparam mem_state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/jt08_adpcmb_memif.sv
// CPU sample-memory access FSM, address pointer, end-of-sample flag and the
// optional read queue (enabled by JT08_ADPCMB_MEMRD_EN).
module jt08_adpcmb_memif
    import jt08_adpcmb_pkg::*;
#(
    parameter int AW = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_mode,
    input  logic          rec,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic [7:0]    din,
    input  logic          ptr_load,
    input  logic [AW-1:0] astart,
    input  logic [AW-1:0] aend,
    input  logic [AW-1:0] alimit,
    input  logic          mem_ack,
    input  logic [7:0]    mem_din,
    input  logic          clr_flag,
    output logic [AW-1:0] ptr,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic [7:0]    mem_dout,
    output logic          brdy,
    output logic          eos_mem,
    output logic [7:0]    rd_data
);

    mem_state_t state;
    logic       op_rd;
    logic       rd_start;
    logic       start_wr;
    logic       start_rd;
    logic       done;
    logic       eos_set;

`ifdef JT08_ADPCMB_MEMRD_EN
    assign rd_start = rd_req & ~rec;
`else
    assign rd_start = 1'b0;
`endif

    assign start_wr = wr_req & cpu_mode & (state == ST_IDLE);
    assign start_rd = rd_start & ~wr_req & cpu_mode & (state == ST_IDLE);
    assign done     = (state == ST_WAIT) & cpu_mode & mem_ack;
    assign eos_set  = done & (ptr == aend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_rd    <= 1'b0;
            mem_dout <= '0;
            brdy     <= 1'b1;
        end else if (state != ST_IDLE && !cpu_mode) begin
            // Playback took the bus: abandon the access, any ack is discarded
            state <= ST_IDLE;
            brdy  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_wr) begin
                        mem_dout <= din;
                        op_rd    <= 1'b0;
                        state    <= ST_REQ;
                        brdy     <= 1'b0;
                    end else if (start_rd) begin
                        op_rd <= 1'b1;
                        state <= ST_REQ;
                        brdy  <= 1'b0;
                    end
                end
                ST_REQ:  state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_ack) begin
                        state <= ST_IDLE;
                        brdy  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            eos_mem <= 1'b0;
        end else begin
            if (ptr_load) begin
                ptr <= astart;
            end else if (done && !eos_set) begin
                if (ptr == alimit) ptr <= '0;
                else               ptr <= ptr + AW'(1);
            end
            if (eos_set)                   eos_mem <= 1'b1;
            else if (ptr_load || clr_flag) eos_mem <= 1'b0;
        end
    end

    assign mem_wr = (state != ST_IDLE) & ~op_rd;

`ifdef JT08_ADPCMB_MEMRD_EN
    logic [7:0] q0;
    logic [7:0] q1;

    // Each accepted read pops the head now and refills the tail on ack,
    // so a pointer load leaves two zero bytes ahead of real data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= '0;
            q1 <= '0;
        end else if (ptr_load) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            if (start_rd)      q0 <= q1;
            if (done && op_rd) q1 <= mem_din;
        end
    end

    assign mem_rd  = (state != ST_IDLE) & op_rd;
    assign rd_data = q0;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_req, rec, mem_din};
    assign mem_rd    = 1'b0;
    assign rd_data   = '0;
`endif

endmodule

// File: rtl/jt08_adpcmb_ctrl.sv
// ADPCM-B register file, START command pulse and sample-memory address mux.
// Optional CPU memory reads are enabled by JT08_ADPCMB_MEMRD_EN.
module jt08_adpcmb_ctrl
    import jt08_adpcmb_pkg::*;
#(
    parameter int AW = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_n,
    input  logic          rd_n,
    input  logic [3:0]    reg_sel,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [15:0]   delta_n,
    output logic [AW-1:0] astart,
    output logic [AW-1:0] aend,
    output logic [AW-1:0] alimit,
    output logic          arepeat,
    output logic          on,
    output logic          clr,
    output logic          acmd_up_b,
    output logic [7:0]    level,
    output logic [1:0]    pan,
    input  logic [AW-1:0] play_addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    input  logic          mem_ack,
    output logic          brdy,
    output logic          eos_mem,
    input  logic          clr_flag
);

    logic [7:0]    ctrl1;
    logic [15:0]   start_a;
    logic [15:0]   stop_a;
    logic [15:0]   limit_a;
    logic          wr_en;
    logic          wr_data;
    logic          rd_data_req;
    logic          ptr_load;
    logic          cpu_mode;
    logic          brdy_mif;
    logic [AW-1:0] ptr;
    logic          unused_ctrl;

    assign wr_en       = ~wr_n;
    assign wr_data     = wr_en & (reg_sel == REG_DATA);
    assign rd_data_req = ~rd_n & (reg_sel == REG_DATA);
    assign ptr_load    = wr_en & (reg_sel == REG_CTRL1) &
                         din[CTRL1_MEMDATA] & ~ctrl1[CTRL1_MEMDATA];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl1     <= '0;
            pan       <= '0;
            start_a   <= '0;
            stop_a    <= '0;
            limit_a   <= '0;
            delta_n   <= '0;
            level     <= '0;
            acmd_up_b <= 1'b0;
        end else begin
            acmd_up_b <= wr_en & (reg_sel == REG_CTRL1) & din[CTRL1_START];
            if (wr_en) begin
                case (reg_sel)
                    REG_CTRL1:   ctrl1         <= din;
                    REG_CTRL2:   pan           <= din[7:6];
                    REG_START_L: start_a[7:0]  <= din;
                    REG_START_H: start_a[15:8] <= din;
                    REG_STOP_L:  stop_a[7:0]   <= din;
                    REG_STOP_H:  stop_a[15:8]  <= din;
                    REG_DELTA_L: delta_n[7:0]  <= din;
                    REG_DELTA_H: delta_n[15:8] <= din;
                    REG_LEVEL:   level         <= din;
                    REG_LIMIT_L: limit_a[7:0]  <= din;
                    REG_LIMIT_H: limit_a[15:8] <= din;
                    default: ;
                endcase
            end
        end
    end

    assign astart   = AW'({start_a, {ADDR_SHIFT{1'b0}}});
    assign aend     = AW'({stop_a,  {ADDR_SHIFT{1'b1}}});
    assign alimit   = AW'({limit_a, {ADDR_SHIFT{1'b1}}});
    assign arepeat  = ctrl1[CTRL1_REPEAT];
    assign on       = ctrl1[CTRL1_START];
    assign clr      = ctrl1[CTRL1_RESET];
    assign cpu_mode = ctrl1[CTRL1_MEMDATA] & ~ctrl1[CTRL1_START] & ~ctrl1[CTRL1_RESET];
    assign brdy     = brdy_mif & ~ctrl1[CTRL1_START];

    assign unused_ctrl = ^ctrl1[3:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_addr <= '0;
        else     mem_addr <= cpu_mode ? ptr : play_addr;
    end

    jt08_adpcmb_memif #(.AW(AW)) u_memif (
        .clk      (clk),
        .rst      (rst),
        .cpu_mode (cpu_mode),
        .rec      (ctrl1[CTRL1_REC]),
        .wr_req   (wr_data),
        .rd_req   (rd_data_req),
        .din      (din),
        .ptr_load (ptr_load),
        .astart   (astart),
        .aend     (aend),
        .alimit   (alimit),
        .mem_ack  (mem_ack),
        .mem_din  (mem_din),
        .clr_flag (clr_flag),
        .ptr      (ptr),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_dout (mem_dout),
        .brdy     (brdy_mif),
        .eos_mem  (eos_mem),
        .rd_data  (dout)
    );

endmodule
